ddr_region_fetch: RTL
=====================

# ddr_region_fetch

Synthesizable fetch sequencer that drains the DDR image laid out for the accelerator: one config word at the CFG region, then the ACT, FLGACT, WEI and FLGWEI regions of REGION_WORDS words each. It sits between the AXI read-master port (simplified request/data handshake) and the global-buffer writers. It decodes the config word into layer fields and streams each region's words downstream with a region tag.

## Interface
- DATA_WIDTH, `PORT_DATAWIDTH: width of one DDR word / read beat.
- ADDR_WIDTH, 32: byte address width.
- REGION_WORDS, 4096: words per data region; must be a multiple of BURST_BEATS.
- BURST_BEATS, 16: beats per read burst.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a fetch pass; sampled only in IDLE.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- err  out  1  sticky error flag; cleared by start.
- cfg_base, act_base, flgact_base, wei_base, flgwei_base  in  ADDR_WIDTH each  region byte base addresses.
- rd_req_valid / rd_req_ready  out / in  1  read request handshake.
- rd_req_addr  out  ADDR_WIDTH  burst byte address.
- rd_req_len  out  8  beats-1.
- rd_data_valid / rd_data_ready  in / out  1  read data handshake.
- rd_data  in  DATA_WIDTH  read beat.
- rd_data_last  in  1  last beat of a burst.
- out_valid / out_ready  out / in  1  downstream stream handshake.
- out_data  out  DATA_WIDTH  region word.
- out_region  out  3  region tag: 1 ACT, 2 FLGACT, 3 WEI, 4 FLGWEI.
- out_last  out  1  last word of the region.
- cfg_valid  out  1  config fields valid; held until the next start.
- cfg_len_row[3:0], cfg_dep_blk[4:0], cfg_num_blk[4:0], cfg_num_frm[4:0], cfg_num_pat[7:0], cfg_num_lay[7:0], cfg_pool[8:0]  out  decoded fields.

## Operation
- FSM states: IDLE, CFG_REQ, CFG_DAT, DATA_REQ, DATA_DAT, DONE.
- IDLE, start=1: clear err and cfg_valid, then go to CFG_REQ.
- CFG_REQ: issue a request at cfg_base with len=0.
- CFG_DAT: rd_data_ready=1. On the beat, latch the fields from rd_data, LSB-aligned:
  - pool [8:0], num_lay [16:9], num_pat [24:17], num_frm [29:25]
  - num_blk [34:30], dep_blk [39:35], len_row [43:40]
  - Set cfg_valid, select region ACT with burst index 0, go to DATA_REQ.
- DATA_REQ: rd_req_addr = base(region) + burst_idx*BURST_BEATS*(DATA_WIDTH/8); rd_req_len = BURST_BEATS-1. On handshake go to DATA_DAT.
- DATA_DAT, combinational pass-through:
  - out_valid = rd_data_valid, rd_data_ready = out_ready, out_data = rd_data.
  - A beat counts only when rd_data_valid and out_ready are both high.
  - out_last is asserted on the final beat of the final burst of the region.
- After BURST_BEATS beats: increment burst_idx and return to DATA_REQ. After the last burst, advance the region ACT→FLGACT→WEI→FLGWEI; after FLGWEI go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Only one burst is outstanding at a time. A pass with defaults is 1 + 4*256 = 1025 requests and 16384 output beats.
- Error conditions:
  - A base other than cfg_base that is not aligned to BURST_BEATS*DATA_WIDTH/8: low bits forced to zero, err set when start is taken.
  - rd_data_last disagreeing with the internal beat count (early or missing): err set; the internal counter governs.
- start while busy, including in the DONE cycle, is ignored.

## Timing
- Reset values:
  - busy, done, err, cfg_valid, rd_req_valid, rd_data_ready, out_valid, out_last = 0.
  - rd_req_addr, rd_req_len, out_region, all cfg fields = 0; FSM in IDLE.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- rd_req_valid is registered. addr and len stay stable while valid=1 and ready=0.
- cfg fields and cfg_valid update one cycle after the config beat.
- Data path latency is 0 cycles; out_region and out_last are registered against the counters.
- Reset asserted mid-pass returns every output to its reset value immediately. The next start restarts from CFG with no residue.

## Structure
- Shared package ddr_fetch_pkg holds:
  - region encoding constants (CFG=0, ACT=1, FLGACT=2, WEI=3, FLGWEI=4)
  - FSM state encoding
  - cfg field LSB/width constants
- PORT_DATAWIDTH comes from dw_params_presim.vh.
- One sub-module, ddr_fetch_burst_cnt, holds the beat/burst counters, terminal flags and address computation.

## Test plan
- Normal pass, bases 0x0800_0000 / 0x0800_6000 / 0x0801_0000 / 0x0802_0000 / 0x0803_0000, cfg word {15,31,1,3,0,7,10}, ready always high -> fields 15, 31, 1, 3, 0, 7, 10; 1025 requests; 4×4096 beats in memory order; out_last exactly 4 times; one done pulse.
- rd_req_ready held low 5 cycles -> rd_req_addr and len stable; second ACT request at 0x0800_6100 (DATA_WIDTH=128).
- out_ready random 50% -> rd_data_ready mirrors it; no beat lost or duplicated; sequence matches the image.
- act_base=0x0800_6004 -> err=1; first ACT address 0x0800_6000.
- rd_data_last on beat 10 of a burst -> err=1; the burst still consumes 16 beats.
- rst_n low during WEI data -> all outputs at reset values. start while busy is ignored. A new start yields a full correct pass.

Source files
------------

// File: rtl/ddr_fetch_pkg.sv
// ddr_fetch_pkg: region tags, FSM encoding and config-word field layout
// shared by the DDR region fetch sequencer.
package ddr_fetch_pkg;
  // Beat width of the presim build.
  localparam int PORT_DATAWIDTH = 128;
  localparam logic [2:0] REG_CFG    = 3'd0;
  localparam logic [2:0] REG_ACT    = 3'd1;
  localparam logic [2:0] REG_FLGACT = 3'd2;
  localparam logic [2:0] REG_WEI    = 3'd3;
  localparam logic [2:0] REG_FLGWEI = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE, S_CFG_REQ, S_CFG_DAT, S_DATA_REQ, S_DATA_DAT, S_DONE
  } state_e;
  localparam int POOL_LSB = 0;
  localparam int POOL_W   = 9;
  localparam int LAY_LSB  = 9;
  localparam int LAY_W    = 8;
  localparam int PAT_LSB  = 17;
  localparam int PAT_W    = 8;
  localparam int FRM_LSB  = 25;
  localparam int FRM_W    = 5;
  localparam int BLK_LSB  = 30;
  localparam int BLK_W    = 5;
  localparam int DEP_LSB  = 35;
  localparam int DEP_W    = 5;
  localparam int ROW_LSB  = 40;
  localparam int ROW_W    = 4;
  localparam int CFG_BITS = 44;
endpackage

// File: rtl/ddr_fetch_burst_cnt.sv
// ddr_fetch_burst_cnt: beat/burst/region counters and the burst address
// for the counter values about to be loaded.
module ddr_fetch_burst_cnt import ddr_fetch_pkg::*; #(
  parameter int ADDR_WIDTH   = 32,
  parameter int REGION_WORDS = 4096,
  parameter int BURST_BEATS  = 16,
  parameter int BURST_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  beat,
  input  logic [ADDR_WIDTH-1:0] act_base,
  input  logic [ADDR_WIDTH-1:0] flgact_base,
  input  logic [ADDR_WIDTH-1:0] wei_base,
  input  logic [ADDR_WIDTH-1:0] flgwei_base,
  output logic [2:0]            region_q,
  output logic                  last_beat,
  output logic                  pass_end,
  output logic                  fin_d,
  output logic [ADDR_WIDTH-1:0] addr_d
);
  localparam int NB = REGION_WORDS / BURST_BEATS;
  localparam int CW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;

  logic [CW-1:0]         beat_q, beat_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [2:0]            region_d;
  logic                  last_burst, region_end;
  logic [ADDR_WIDTH-1:0] base_d;

  always_comb begin
    last_beat  = beat_q == CW'(BURST_BEATS - 1);
    last_burst = burst_q == BW'(NB - 1);
    region_end = last_beat && last_burst;
    pass_end   = region_end && region_q == REG_FLGWEI;
    beat_d     = clr ? '0 : beat ? (last_beat ? '0 : beat_q + 1'b1) : beat_q;
    burst_d    = clr ? '0 : (beat && last_beat) ? (last_burst ? '0 : burst_q + 1'b1) : burst_q;
    region_d   = clr ? REG_ACT : (beat && region_end) ? (pass_end ? REG_CFG : region_q + 3'd1) : region_q;
    fin_d      = beat_d == CW'(BURST_BEATS - 1) && burst_d == BW'(NB - 1);
    base_d     = region_d == REG_FLGACT ? flgact_base :
                 region_d == REG_WEI    ? wei_base    :
                 region_d == REG_FLGWEI ? flgwei_base : act_base;
    addr_d     = base_d + ADDR_WIDTH'(burst_d) * ADDR_WIDTH'(BURST_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      burst_q  <= '0;
      region_q <= REG_CFG;
    end else begin
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      region_q <= region_d;
    end
  end
endmodule

// File: rtl/ddr_region_fetch.sv
// ddr_region_fetch: reads the config word, then streams the ACT, FLGACT,
// WEI and FLGWEI regions burst by burst to the global-buffer writers.
module ddr_region_fetch import ddr_fetch_pkg::*; #(
  parameter int DATA_WIDTH   = PORT_DATAWIDTH,
  parameter int ADDR_WIDTH   = 32,
  parameter int REGION_WORDS = 4096,
  parameter int BURST_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] act_base,
  input  logic [ADDR_WIDTH-1:0] flgact_base,
  input  logic [ADDR_WIDTH-1:0] wei_base,
  input  logic [ADDR_WIDTH-1:0] flgwei_base,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic [7:0]            rd_req_len,
  input  logic                  rd_data_valid,
  output logic                  rd_data_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_region,
  output logic                  out_last,
  output logic                  cfg_valid,
  output logic [3:0]            cfg_len_row,
  output logic [4:0]            cfg_dep_blk,
  output logic [4:0]            cfg_num_blk,
  output logic [4:0]            cfg_num_frm,
  output logic [7:0]            cfg_num_pat,
  output logic [7:0]            cfg_num_lay,
  output logic [8:0]            cfg_pool
);
  localparam int BURST_BYTES = BURST_BEATS * (DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_BYTES - 1);

  state_e                state_q, state_d;
  logic                  err_q, err_d, cfg_valid_q, cfg_valid_d;
  logic                  rd_req_valid_q, rd_req_valid_d, out_last_q, out_last_d;
  logic [ADDR_WIDTH-1:0] rd_req_addr_q, rd_req_addr_d, addr_d;
  logic [7:0]            rd_req_len_q, rd_req_len_d;
  logic [CFG_BITS-1:0]   cfg_q, cfg_d;
  logic                  misaligned, clr, beat, last_beat, pass_end, fin_d;
  logic [2:0]            region_q;

  ddr_fetch_burst_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH), .REGION_WORDS(REGION_WORDS),
    .BURST_BEATS(BURST_BEATS), .BURST_BYTES(BURST_BYTES)
  ) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .beat(beat),
    .act_base(act_base & ALIGN_MASK), .flgact_base(flgact_base & ALIGN_MASK),
    .wei_base(wei_base & ALIGN_MASK), .flgwei_base(flgwei_base & ALIGN_MASK),
    .region_q(region_q), .last_beat(last_beat), .pass_end(pass_end),
    .fin_d(fin_d), .addr_d(addr_d)
  );

  assign misaligned = |((act_base | flgact_base | wei_base | flgwei_base) & ~ALIGN_MASK);

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_d         = cfg_q;
    clr           = 1'b0;
    beat          = 1'b0;
    rd_data_ready = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_CFG_REQ;
        err_d       = misaligned;
        cfg_valid_d = 1'b0;
      end
      S_CFG_REQ: if (rd_req_ready) state_d = S_CFG_DAT;
      S_CFG_DAT: begin
        rd_data_ready = 1'b1;
        if (rd_data_valid) begin
          cfg_d       = rd_data[CFG_BITS-1:0];
          cfg_valid_d = 1'b1;
          clr         = 1'b1;
          state_d     = S_DATA_REQ;
          err_d       = err_q | ~rd_data_last;
        end
      end
      S_DATA_REQ: if (rd_req_ready) state_d = S_DATA_DAT;
      S_DATA_DAT: begin
        rd_data_ready = out_ready;
        out_valid     = rd_data_valid;
        out_data      = rd_data;
        beat          = rd_data_valid && out_ready;
        // The beat counter decides burst boundaries; rd_data_last is only cross-checked.
        if (beat && rd_data_last != last_beat) err_d = 1'b1;
        if (beat && last_beat) state_d = pass_end ? S_DONE : S_DATA_REQ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rd_req_valid_d = state_d == S_CFG_REQ || state_d == S_DATA_REQ;
    rd_req_addr_d  = state_d == S_CFG_REQ ? cfg_base : state_d == S_DATA_REQ ? addr_d : rd_req_addr_q;
    rd_req_len_d   = state_d == S_CFG_REQ ? 8'd0 : state_d == S_DATA_REQ ? 8'(BURST_BEATS - 1) : rd_req_len_q;
    out_last_d     = state_d == S_DATA_DAT && fin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      err_q          <= 1'b0;
      cfg_valid_q    <= 1'b0;
      cfg_q          <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_len_q   <= '0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      cfg_valid_q    <= cfg_valid_d;
      cfg_q          <= cfg_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_req_addr_q  <= rd_req_addr_d;
      rd_req_len_q   <= rd_req_len_d;
      out_last_q     <= out_last_d;
    end
  end

  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign err          = err_q;
  assign cfg_valid    = cfg_valid_q;
  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign rd_req_len   = rd_req_len_q;
  assign out_region   = region_q;
  assign out_last     = out_last_q;
  assign cfg_pool     = cfg_q[POOL_LSB +: POOL_W];
  assign cfg_num_lay  = cfg_q[LAY_LSB +: LAY_W];
  assign cfg_num_pat  = cfg_q[PAT_LSB +: PAT_W];
  assign cfg_num_frm  = cfg_q[FRM_LSB +: FRM_W];
  assign cfg_num_blk  = cfg_q[BLK_LSB +: BLK_W];
  assign cfg_dep_blk  = cfg_q[DEP_LSB +: DEP_W];
  assign cfg_len_row  = cfg_q[ROW_LSB +: ROW_W];
endmodule
